audio_smooth_fifo: RTL and testbench

AUDIO_SMOOTH_FIFO -- requirements
Module: audio_smooth_fifo

---
 rtl/audio_pkg.sv | 16 +
 rtl/audio_fifo_ram.sv | 24 ++
 rtl/audio_smooth_fifo.sv | 130 +++++++++++++
 tb/tb_audio_smooth_fifo.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample/coefficient widths, sample type and log2 helper.
package audio_pkg;

  localparam int AUDIO_DATA_W = 18;
  localparam int AUDIO_COEF_W = 5;

  typedef logic signed [AUDIO_DATA_W-1:0] sample_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/audio_fifo_ram.sv
// Frame storage: one synchronous write port, one asynchronous read port, no reset on contents.
module audio_fifo_ram
  import audio_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 64
)(
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/audio_smooth_fifo.sv
// Frame FIFO with 4-phase push/pop handshakes and a per-channel first-order IIR
// smoother applied to frames as they are popped.
module audio_smooth_fifo
  import audio_pkg::*;
#(
  parameter int DATA_W   = AUDIO_DATA_W,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 64,
  parameter int COEF_W   = AUDIO_COEF_W
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*DATA_W-1:0]   data_in,
  input  logic                         ready,
  output logic                         received,
  input  logic                         ack,
  output logic [CHANNELS*DATA_W-1:0]   data_out,
  output logic                         valid,
  output logic                         full,
  output logic [clog2(DEPTH):0]        count,
  input  logic [COEF_W:0]              alpha,
  input  logic                         smooth_en,
  input  logic                         flush,
  output logic                         underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int FW = CHANNELS * DATA_W;
  localparam int IW = DATA_W + COEF_W + 2;
  localparam logic [AW:0]     PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [COEF_W:0] UNITY    = {1'b1, {COEF_W{1'b0}}};

  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          r_ready_q, r_ready_arm, r_ack_q, r_ack_arm;
  logic          r_push_pend, r_received, r_underflow;
  logic [FW-1:0] r_data_out;

  logic [AW:0]     w_count;
  logic            w_full, w_valid;
  logic            w_ready_rise, w_ack_rise, w_push, w_pop;
  logic [FW-1:0]   w_rd_frame, w_smooth;
  logic [COEF_W:0] w_a, w_b;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == FULL_CNT);
  assign w_valid = (w_count != '0);

  // Arm flags keep a request held high across reset release from looking like an edge.
  assign w_ready_rise = ready & ~r_ready_q & r_ready_arm;
  assign w_ack_rise   = ack & ~r_ack_q & r_ack_arm;
  assign w_push       = (w_ready_rise | r_push_pend) & ready & ~w_full & ~flush;
  assign w_pop        = w_ack_rise & w_valid & ~flush;

  audio_fifo_ram #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (r_rd_ptr[AW-1:0]),
    .rdata (w_rd_frame)
  );

  assign w_a = (alpha > UNITY) ? UNITY : alpha;
  assign w_b = UNITY - w_a;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic signed [IW-1:0] w_x, w_y, w_a_s, w_b_s, w_acc;
    logic                 w_unused_bits;

    assign w_x   = {{(IW-DATA_W){w_rd_frame[ch*DATA_W+DATA_W-1]}}, w_rd_frame[ch*DATA_W +: DATA_W]};
    assign w_y   = {{(IW-DATA_W){r_data_out[ch*DATA_W+DATA_W-1]}}, r_data_out[ch*DATA_W +: DATA_W]};
    assign w_a_s = {{(IW-COEF_W-1){1'b0}}, w_a};
    assign w_b_s = {{(IW-COEF_W-1){1'b0}}, w_b};
    assign w_acc = w_b_s * w_y + w_a_s * w_x;

    // Slicing above the fraction bits is the floor (>>>) shift; a+b=1 keeps it in range.
    assign w_smooth[ch*DATA_W +: DATA_W] = w_acc[COEF_W +: DATA_W];
    assign w_unused_bits = ^{w_acc[IW-1:COEF_W+DATA_W], w_acc[COEF_W-1:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ready_q   <= 1'b0;
      r_ready_arm <= 1'b0;
      r_ack_q     <= 1'b0;
      r_ack_arm   <= 1'b0;
      r_push_pend <= 1'b0;
      r_received  <= 1'b0;
      r_underflow <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_ready_q <= ready;
      r_ack_q   <= ack;
      if (!ready) r_ready_arm <= 1'b1;
      if (!ack)   r_ack_arm   <= 1'b1;

      if (flush || !ready || w_push) r_push_pend <= 1'b0;
      else if (w_ready_rise)         r_push_pend <= 1'b1;

      if (w_push)      r_received <= 1'b1;
      else if (!ready) r_received <= 1'b0;

      if (w_ack_rise && !w_valid) r_underflow <= 1'b1;

      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end

      if (w_pop) r_data_out <= smooth_en ? w_smooth : w_rd_frame;
    end
  end

  assign received  = r_received;
  assign data_out  = r_data_out;
  assign valid     = w_valid;
  assign full      = w_full;
  assign count     = w_count;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_audio_smooth_fifo.sv
// Directed bench for audio_smooth_fifo: fill/backpressure, bypass order, smoothing table, corner sequences.
module tb_audio_smooth_fifo;
  import audio_pkg::*;

  localparam int DW = 18;
  localparam int FW = 36;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] data_in;
  logic          ready, received, ack;
  logic [FW-1:0] data_out;
  logic          valid, full;
  logic [6:0]    count;
  logic [5:0]    alpha;
  logic          smooth_en, flush, underflow;

  always #5 clk = ~clk;

  audio_smooth_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .ready     (ready),
    .received  (received),
    .ack       (ack),
    .data_out  (data_out),
    .valid     (valid),
    .full      (full),
    .count     (count),
    .alpha     (alpha),
    .smooth_en (smooth_en),
    .flush     (flush),
    .underflow (underflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int op;      // 0 push, 1 pop, 2 flush
    int c0, c1;  // pushed frame
    int alpha;
    int se;
    int e0, e1;  // expected data_out channels afterwards
    int ecnt;    // expected count afterwards
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic sample_t ch(input int c);
    return data_out[c*DW +: DW];
  endfunction

  function automatic logic [FW-1:0] mk(input int c0, input int c1);
    return {sample_t'(c1), sample_t'(c0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input int c0, input int c1);
    data_in = mk(c0, c1);
    ready = 1'b1;
    for (int i = 0; i < 200 && !received; i++) tick();
    chk("push_received", longint'(received), 1);
    ready = 1'b0;
    tick();
  endtask

  task automatic do_pop(input int a, input int se);
    alpha = 6'(a);
    smooth_en = (se != 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    alpha = 6'd17;
    smooth_en = ~smooth_en;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 0, 2, -2, 63};
    vecs[1]  = '{1, 0, 0, 0, 0, 3, -3, 62};
    vecs[2]  = '{1, 0, 0, 0, 0, 4, -4, 61};
    vecs[3]  = '{1, 0, 0, 0, 0, 5, -5, 60};
    vecs[4]  = '{2, 0, 0, 0, 0, 5, -5, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 5, -5, 1};
    vecs[6]  = '{0, 16384, -16384, 0, 0, 5, -5, 2};
    vecs[7]  = '{0, 16384, -16384, 0, 0, 5, -5, 3};
    vecs[8]  = '{0, -1, 1000, 0, 0, 5, -5, 4};
    vecs[9]  = '{0, 0, 0, 0, 0, 5, -5, 5};
    vecs[10] = '{0, -1, -1, 0, 0, 5, -5, 6};
    vecs[11] = '{0, 12345, -7, 0, 0, 5, -5, 7};
    vecs[12] = '{0, 500, 500, 0, 0, 5, -5, 8};
    vecs[13] = '{1, 0, 0, 0, 0, 0, 0, 7};
    vecs[14] = '{1, 0, 0, 2, 1, 1024, -1024, 6};
    vecs[15] = '{1, 0, 0, 2, 1, 1984, -1984, 5};
    vecs[16] = '{1, 0, 0, 32, 1, -1, 1000, 4};
    vecs[17] = '{1, 0, 0, 0, 0, 0, 0, 3};
    vecs[18] = '{1, 0, 0, 1, 1, -1, -1, 2};
    vecs[19] = '{1, 0, 0, 63, 1, 12345, -7, 1};
    vecs[20] = '{1, 0, 0, 0, 1, 12345, -7, 0};

    reset = 1'b0; ready = 1'b0; ack = 1'b0; flush = 1'b0;
    alpha = '0; smooth_en = 1'b0; data_in = '0;
    repeat (3) tick();
    chk("rst_received", longint'(received), 0);
    chk("rst_valid", longint'(valid), 0);
    chk("rst_full", longint'(full), 0);
    chk("rst_count", longint'(count), 0);
    chk("rst_underflow", longint'(underflow), 0);
    chk("rst_data_out", longint'(data_out), 0);
    reset = 1'b1;
    tick();

    // Fill to DEPTH, then a held-off 65th push released by one pop
    for (int k = 1; k <= 64; k++) do_push(k, -k);
    chk("fill_full", longint'(full), 1);
    chk("fill_count", longint'(count), 64);
    data_in = mk(65, -65);
    ready = 1'b1;
    repeat (3) tick();
    chk("held_received", longint'(received), 0);
    chk("held_count", longint'(count), 64);
    ack = 1'b1;
    tick();
    chk("pop1_ch0", ch(0), 1);
    chk("pop1_ch1", ch(1), -1);
    chk("pop1_count", longint'(count), 63);
    ack = 1'b0;
    tick();
    chk("late_received", longint'(received), 1);
    chk("late_count", longint'(count), 64);
    ready = 1'b0;
    tick();
    chk("late_received_clr", longint'(received), 0);

    for (int i = 0; i < 21; i++) begin
      case (vecs[i].op)
        0: do_push(vecs[i].c0, vecs[i].c1);
        1: do_pop(vecs[i].alpha, vecs[i].se);
        default: begin
          flush = 1'b1;
          tick();
          flush = 1'b0;
          tick();
        end
      endcase
      chk($sformatf("vec%0d_ch0", i), ch(0), vecs[i].e0);
      chk($sformatf("vec%0d_ch1", i), ch(1), vecs[i].e1);
      chk($sformatf("vec%0d_count", i), longint'(count), vecs[i].ecnt);
    end

    // Pop while empty
    smooth_en = 1'b0;
    chk("uf_before", longint'(underflow), 0);
    ack = 1'b1;
    tick();
    chk("uf_set", longint'(underflow), 1);
    chk("uf_ch0", ch(0), 12345);
    chk("uf_valid", longint'(valid), 0);
    ack = 1'b0;
    tick();
    chk("uf_count", longint'(count), 0);
    chk("uf_sticky", longint'(underflow), 1);

    // Simultaneous push and pop at count 3
    do_push(10, -10);
    do_push(20, -20);
    do_push(30, -30);
    chk("sim_pre_count", longint'(count), 3);
    data_in = mk(40, -40);
    alpha = '0;
    smooth_en = 1'b0;
    ready = 1'b1;
    ack = 1'b1;
    tick();
    chk("sim_count", longint'(count), 3);
    chk("sim_ch0", ch(0), 10);
    chk("sim_received", longint'(received), 1);
    ready = 1'b0;
    ack = 1'b0;
    tick();
    chk("sim_count_after", longint'(count), 3);

    // Flush at count 10
    for (int k = 5; k <= 11; k++) do_push(k * 10, -k * 10);
    chk("fl_pre_count", longint'(count), 10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_count", longint'(count), 0);
    chk("fl_valid", longint'(valid), 0);
    chk("fl_ch0", ch(0), 10);
    tick();

    // Reset mid-handshake with ready held high
    data_in = mk(77, -77);
    ready = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("mrst_received", longint'(received), 0);
    chk("mrst_data_out", longint'(data_out), 0);
    chk("mrst_underflow", longint'(underflow), 0);
    tick();
    tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("mrst_held_received", longint'(received), 0);
    chk("mrst_held_count", longint'(count), 0);
    ready = 1'b0;
    tick();
    ready = 1'b1;
    tick();
    chk("mrst_retry_received", longint'(received), 1);
    chk("mrst_retry_count", longint'(count), 1);
    ready = 1'b0;
    tick();
    do_pop(0, 0);
    chk("mrst_pop_ch0", ch(0), 77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
